// File: rtl/srx_pipe_pkg.sv
// Shared definitions for the pipelined right shifter: operand widths and the
// per-stage record that travels down the pipe.
package srx_pipe_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;
  localparam int TAG_W   = 5;
  localparam int STAGES  = 5;

  typedef struct packed {
    logic               valid;
    logic [WIDTH-1:0]   data;
    logic [SHAMT_W-1:0] shamt;
    logic               fill;
    logic [TAG_W-1:0]   tag;
  } srx_rec_t;

  // Right shift by a fixed amount, back-filling vacated MSBs with 'fill'.
  function automatic logic [WIDTH-1:0] fill_shift(input logic [WIDTH-1:0] data,
                                                  input logic             fill,
                                                  input int unsigned      amount);
    logic [WIDTH-1:0] fill_mask;
    fill_mask = ~({WIDTH{1'b1}} >> amount);
    return (data >> amount) | (fill_mask & {WIDTH{fill}});
  endfunction

endpackage

// File: rtl/srx_stage.sv
// One stage of the right-shift pipe: resolves a single shift-amount bit and
// registers the whole record, holding on stall and dropping valid on flush.
module srx_stage
  import srx_pipe_pkg::*;
#(
  parameter int SHIFT         = 16,
  parameter bit CLEAR_PAYLOAD = 1'b0
) (
  input  logic     clock,
  input  logic     reset_n,
  input  logic     flush,
  input  logic     advance,
  input  srx_rec_t prev,
  output srx_rec_t cur
);

  localparam int SEL = $clog2(SHIFT);

  srx_rec_t nxt;

  always_comb begin
    nxt      = prev;
    nxt.data = prev.shamt[SEL] ? fill_shift(prev.data, prev.fill, SHIFT) : prev.data;
  end

  // Only the last stage clears its payload, so the visible outputs read 0 after reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cur.valid <= 1'b0;
      if (CLEAR_PAYLOAD) begin
        cur.data  <= '0;
        cur.shamt <= '0;
        cur.fill  <= 1'b0;
        cur.tag   <= '0;
      end
    end else if (flush) begin
      cur.valid <= 1'b0;
    end else if (advance) begin
      cur <= nxt;
    end
  end

endmodule

// File: rtl/srx_pipe.sv
// Five-stage pipelined right shifter (sra/srl) with valid/ready flow control,
// a global stall and a synchronous flush.
module srx_pipe #(
  parameter int WIDTH = srx_pipe_pkg::WIDTH,
  parameter int TAG_W = srx_pipe_pkg::TAG_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [4:0]       in_shamt,
  input  logic             in_arith,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);

  import srx_pipe_pkg::*;

  logic     advance;
  srx_rec_t entry;
  srx_rec_t stage_q [STAGES];

  assign advance  = !(out_valid && !out_ready);
  assign in_ready = advance && !flush;

  // The sign fill is decided once at entry so later stages never look at the MSB again.
  always_comb begin
    entry.valid = in_valid && in_ready;
    entry.data  = in_data;
    entry.shamt = in_shamt;
    entry.fill  = in_arith && in_data[WIDTH-1];
    entry.tag   = in_tag;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      srx_stage #(
        .SHIFT        (1 << (STAGES - 1 - k)),
        .CLEAR_PAYLOAD(1'b0)
      ) u_stage (
        .clock  (clock),
        .reset_n(reset_n),
        .flush  (flush),
        .advance(advance),
        .prev   (entry),
        .cur    (stage_q[k])
      );
    end else begin : g_rest
      srx_stage #(
        .SHIFT        (1 << (STAGES - 1 - k)),
        .CLEAR_PAYLOAD(k == STAGES - 1)
      ) u_stage (
        .clock  (clock),
        .reset_n(reset_n),
        .flush  (flush),
        .advance(advance),
        .prev   (stage_q[k-1]),
        .cur    (stage_q[k])
      );
    end
  end

  assign out_valid = stage_q[STAGES-1].valid;
  assign out_data  = stage_q[STAGES-1].data;
  assign out_tag   = stage_q[STAGES-1].tag;

  logic unused_tail;
  assign unused_tail = ^{stage_q[STAGES-1].shamt, stage_q[STAGES-1].fill};

endmodule

// File: tb/tb_srx_pipe.sv
// Self-checking bench for srx_pipe: directed scenarios plus random traffic,
// compared against a delay-line reference model with one-step arithmetic shifts.
module tb_srx_pipe;

  logic        clock;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic        in_arith;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;

  int vec_count   = 0;
  int miscompares = 0;
  int fired       = 0;
  bit model_known = 1'b0;

  bit          m_valid [5];
  logic [31:0] m_data  [5];
  logic [4:0]  m_tag   [5];

  srx_pipe dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_shamt (in_shamt),
    .in_arith (in_arith),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_tag  (out_tag)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input int s, input bit a);
    logic signed [31:0] sd;
    logic signed [31:0] r;
    if (a) begin
      sd = d;
      r  = sd >>> s;
      return r;
    end
    return d >> s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs just after an edge, check in_ready, step the model, check outputs.
  task automatic applyStimulus(input bit v, input logic [31:0] d, input logic [4:0] s,
                               input bit a, input logic [4:0] t, input bit ordy,
                               input bit fl, input bit rn);
    bit exp_adv;
    bit exp_ready;
    in_valid  = v;
    in_data   = d;
    in_shamt  = s;
    in_arith  = a;
    in_tag    = t;
    out_ready = ordy;
    flush     = fl;
    reset_n   = rn;
    #3;
    exp_adv   = !(m_valid[4] && !ordy);
    exp_ready = exp_adv && !fl;
    if (model_known) checkOutput("in_ready", 32'(in_ready), 32'(exp_ready));
    if (out_valid === 1'b1 && ordy) fired++;
    @(posedge clock);
    if (!rn) begin
      for (int k = 0; k < 5; k++) m_valid[k] = 1'b0;
      m_data[4]   = '0;
      m_tag[4]    = '0;
      model_known = 1'b1;
    end else if (fl) begin
      for (int k = 0; k < 5; k++) m_valid[k] = 1'b0;
    end else if (exp_adv) begin
      for (int k = 4; k > 0; k--) begin
        m_valid[k] = m_valid[k-1];
        m_data[k]  = m_data[k-1];
        m_tag[k]   = m_tag[k-1];
      end
      m_valid[0] = v && exp_ready;
      m_data[0]  = ref_shift(d, int'(s), a);
      m_tag[0]   = t;
    end
    #1;
    checkOutput("out_valid", 32'(out_valid), 32'(m_valid[4]));
    if (m_valid[4]) begin
      checkOutput("out_data", out_data, m_data[4]);
      checkOutput("out_tag", 32'(out_tag), 32'(m_tag[4]));
    end
    if (!rn) begin
      checkOutput("rst_data", out_data, 32'h0);
      checkOutput("rst_tag", 32'(out_tag), 32'h0);
    end
  endtask

  task automatic issue(input logic [31:0] d, input logic [4:0] s, input bit a, input logic [4:0] t);
    applyStimulus(1'b1, d, s, a, t, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
  endtask

  // Single op then wait for it: the result must be visible right after the fourth idle cycle.
  task automatic directedOp(input string name, input logic [31:0] d, input logic [4:0] s,
                            input bit a, input logic [4:0] t, input logic [31:0] want);
    issue(d, s, a, t);
    idle(4);
    checkOutput({name, "_valid"}, 32'(out_valid), 32'h1);
    checkOutput({name, "_data"}, out_data, want);
    checkOutput({name, "_tag"}, 32'(out_tag), 32'(t));
  endtask

  initial begin
    int base;
    logic [31:0] rd;
    for (int k = 0; k < 5; k++) begin
      m_valid[k] = 1'b0;
      m_data[k]  = '0;
      m_tag[k]   = '0;
    end

    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'h1);
    idle(1);

    directedOp("ext_sra", 32'h8000_0000, 5'd31, 1'b1, 5'd1, 32'hFFFF_FFFF);
    directedOp("ext_srl", 32'h8000_0000, 5'd31, 1'b0, 5'd2, 32'h0000_0001);
    directedOp("pat_sra", 32'hF0F0_F0F0, 5'd4, 1'b1, 5'd3, 32'hFF0F_0F0F);
    directedOp("pat_srl", 32'hF0F0_F0F0, 5'd4, 1'b0, 5'd4, 32'h0F0F_0F0F);
    directedOp("sh0_sra", 32'hF0F0_F0F0, 5'd0, 1'b1, 5'd5, 32'hF0F0_F0F0);
    directedOp("sh0_srl", 32'hF0F0_F0F0, 5'd0, 1'b0, 5'd6, 32'hF0F0_F0F0);
    idle(2);

    base = fired;
    for (int i = 0; i < 8; i++) issue(32'h1234_5678 * (i + 1), 5'(i * 3), i[0], 5'(i + 10));
    idle(6);
    checkOutput("thru_count", 32'(fired - base), 32'd8);

    for (int i = 0; i < 5; i++) issue(32'hA5A5_0000 + i, 5'(i + 1), 1'b1, 5'(i + 20));
    base = fired;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'hDEAD_BEEF, 5'd7, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1);
      checkOutput("bp_ready", 32'(in_ready), 32'h0);
    end
    idle(6);
    checkOutput("bp_count", 32'(fired - base), 32'd5);

    base = fired;
    for (int i = 0; i < 3; i++) issue(32'h0BAD_F00D + i, 5'd2, 1'b0, 5'(i + 7));
    applyStimulus(1'b1, 32'hCAFE_0000, 5'd8, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1);
    idle(6);
    checkOutput("flush_count", 32'(fired - base), 32'd0);
    directedOp("post_flush", 32'h8765_4321, 5'd8, 1'b1, 5'd12, 32'hFF87_6543);

    idle(2);
    base = fired;
    for (int i = 0; i < 4; i++) issue(32'h5555_AAAA + i, 5'd1, 1'b0, 5'(i + 1));
    applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
    idle(5);
    checkOutput("reset_count", 32'(fired - base), 32'd0);
    directedOp("post_reset", 32'h7FFF_FFFF, 5'd16, 1'b1, 5'd17, 32'h0000_7FFF);

    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0:       rd = 32'h8000_0000;
        1:       rd = 32'h7FFF_FFFF;
        2:       rd = 32'hFFFF_FFFF;
        default: rd = $urandom;
      endcase
      applyStimulus($urandom_range(0, 3) != 0, rd, 5'($urandom_range(0, 31)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 99) != 0);
    end
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
